adc_sar_engine: RTL



---
 rtl/adc_pkg.sv | 29 ++
 rtl/adc_sar_reg.sv | 67 ++++++
 rtl/adc_sar_engine.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/adc_pkg.sv
// Shared ADC definitions: FSM states, default timing/resolution and the analog
// channel map used by both this engine and the sequencer.
package adc_pkg;

    localparam int DEF_RES_BITS   = 10;
    localparam int DEF_TRACK_CYC  = 4;
    localparam int DEF_SETTLE_CYC = 2;
    localparam int CNT_W          = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRACK,
        ST_CONV,
        ST_DONE,
        ST_RELEASE
    } adc_state_e;

    typedef logic [2:0] adc_ch_t;

    localparam adc_ch_t CH_GND     = 3'd0;
    localparam adc_ch_t CH_VBAT    = 3'd1;
    localparam adc_ch_t CH_VREF    = 3'd2;
    localparam adc_ch_t CH_TEMP    = 3'd3;
    localparam adc_ch_t CH_AIN0    = 3'd4;
    localparam adc_ch_t CH_AIN1    = 3'd5;
    localparam adc_ch_t CH_AIN2    = 3'd6;
    localparam adc_ch_t CH_ADDRESS = 3'd7;

endpackage

// File: rtl/adc_sar_reg.sv
// Successive-approximation register: trial code, bit index and done flag.
// start loads the MSB trial; each step resolves the current bit against cmp.
module adc_sar_reg
    import adc_pkg::*;
#(
    parameter int RES_BITS = DEF_RES_BITS
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic                step_i,
    input  logic                cmp_i,
    output logic [RES_BITS-1:0] code_o,
    output logic [RES_BITS-1:0] code_nxt_o,
    output logic                last_o,
    output logic                done_o
);

    localparam int            IW      = $clog2(RES_BITS);
    localparam logic [IW-1:0] MSB_IDX = IW'(RES_BITS - 1);

    logic [RES_BITS-1:0] code_q, code_d, nxt;
    logic [IW-1:0]       idx_q, idx_d;
    logic                done_q, done_d;

    always_comb begin
        // Code with the bit under trial resolved; the top captures this on the last bit
        nxt = code_q;
        if (!cmp_i) nxt[idx_q] = 1'b0;

        code_d = code_q;
        idx_d  = idx_q;
        done_d = done_q;
        if (start_i) begin
            code_d          = '0;
            code_d[MSB_IDX] = 1'b1;
            idx_d           = MSB_IDX;
            done_d          = 1'b0;
        end else if (step_i && !done_q) begin
            code_d = nxt;
            if (idx_q != '0) begin
                code_d[idx_q - 1'b1] = 1'b1;
                idx_d                = idx_q - 1'b1;
            end else begin
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            code_q <= '0;
            idx_q  <= '0;
            done_q <= 1'b0;
        end else begin
            code_q <= code_d;
            idx_q  <= idx_d;
            done_q <= done_d;
        end
    end

    assign code_o     = code_q;
    assign code_nxt_o = nxt;
    assign last_o     = (idx_q == '0);
    assign done_o     = done_q;

endmodule

// File: rtl/adc_sar_engine.sv
// SAR ADC digital back end: track/hold sequencing, binary search against the
// comparator, and the ready/sample handshake with the ADC sequencer.
module adc_sar_engine
    import adc_pkg::*;
#(
    parameter int RES_BITS   = DEF_RES_BITS,
    parameter int TRACK_CYC  = DEF_TRACK_CYC,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
    input  logic                SCK,
    input  logic                POR,
    input  logic                adc_convert,
    input  logic [2:0]          adc_channel,
    input  logic                adc_sample,
    input  logic                cmp_out,
    output logic                adc_ready,
    output logic [RES_BITS-1:0] adc_data,
    output logic [2:0]          adc_data_ch,
    output logic [RES_BITS-1:0] sar_dac,
    output logic                sh_track,
    output logic [2:0]          mux_sel,
    output logic                adc_busy
);

    localparam logic [CNT_W-1:0] TRACK_LOAD  = CNT_W'(TRACK_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);

    adc_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    adc_ch_t             ch_q, ch_d;
    adc_ch_t             mux_q, mux_d;
    logic                sh_q, sh_d;
    logic                ready_q, ready_d;
    logic [RES_BITS-1:0] data_q, data_d;
    adc_ch_t             data_ch_q, data_ch_d;

    logic                sar_start, sar_step, sar_last, sar_done;
    logic [RES_BITS-1:0] sar_code, sar_code_nxt;

    adc_sar_reg #(.RES_BITS(RES_BITS)) u_sar (
        .clk_i      (SCK),
        .rst_i      (POR),
        .start_i    (sar_start),
        .step_i     (sar_step),
        .cmp_i      (cmp_out),
        .code_o     (sar_code),
        .code_nxt_o (sar_code_nxt),
        .last_o     (sar_last),
        .done_o     (sar_done)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ch_d      = ch_q;
        mux_d     = mux_q;
        sh_d      = sh_q;
        ready_d   = ready_q;
        data_d    = data_q;
        data_ch_d = data_ch_q;
        sar_start = 1'b0;
        sar_step  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                mux_d = adc_channel;
                sh_d  = 1'b1;
                if (adc_convert) begin
                    ch_d    = adc_channel;
                    cnt_d   = TRACK_LOAD;
                    state_d = ST_TRACK;
                end
            end
            ST_TRACK: begin
                if (!adc_convert) begin
                    sh_d    = 1'b1;
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    sh_d      = 1'b0;
                    sar_start = 1'b1;
                    cnt_d     = SETTLE_LOAD;
                    state_d   = ST_CONV;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_CONV: begin
                if (!adc_convert) begin
                    sh_d    = 1'b1;
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    // Last settle cycle: the comparator decides the current bit
                    sar_step = !sar_done;
                    cnt_d    = SETTLE_LOAD;
                    if (sar_last) begin
                        data_d    = sar_code_nxt;
                        data_ch_d = ch_q;
                        ready_d   = 1'b1;
                        sh_d      = 1'b1;
                        state_d   = ST_DONE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                if (adc_sample) begin
                    ready_d = 1'b0;
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!adc_convert) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge SCK or posedge POR) begin
        if (POR) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            ch_q      <= CH_GND;
            mux_q     <= CH_GND;
            sh_q      <= 1'b1;
            ready_q   <= 1'b0;
            data_q    <= '0;
            data_ch_q <= CH_GND;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ch_q      <= ch_d;
            mux_q     <= mux_d;
            sh_q      <= sh_d;
            ready_q   <= ready_d;
            data_q    <= data_d;
            data_ch_q <= data_ch_d;
        end
    end

    assign adc_ready   = ready_q;
    assign adc_data    = data_q;
    assign adc_data_ch = data_ch_q;
    assign sar_dac     = sar_code;
    assign sh_track    = sh_q;
    assign mux_sel     = mux_q;
    assign adc_busy    = (state_q != ST_IDLE);

endmodule
